// File: rtl/pc_sequencer.sv
// Program-counter owner for the MIPS fetch stage: picks the next PC, holds it
// across a multi-cycle instruction-memory handshake and squashes wrong-path fetches.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        exception_i,
  input  logic [31:0] exc_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        fetch_valid_o,
  output logic [31:0] epc_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_exc_q, pend_exc_d;
  logic        squash_q, squash_d;

  logic        redirect_now;
  logic [31:0] redirect_raw;
  logic [31:0] redirect_target;
  logic        handshake;

  // Exception beats jump beats branch; every target is forced word-aligned.
  assign redirect_now    = exception_i | jump_i | branch_taken_i;
  assign redirect_raw    = exception_i ? EXC_VECTOR :
                           jump_i      ? jump_target_i : branch_target_i;
  assign redirect_target = {redirect_raw[31:2], 2'b00};

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign epc_o         = epc_q;
  assign handshake     = imem_req_o & imem_ready_i;
  assign fetch_valid_o = handshake & ~squash_q & ~pend_valid_q & ~redirect_now;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epc_d         = epc_q;
    pend_target_d = pend_target_q;
    pend_valid_d  = pend_valid_q;
    pend_exc_d    = pend_exc_q;
    squash_d      = squash_q;

    if (exception_i) begin
      epc_d = exc_pc_i;
    end

    unique case (state_q)
      REQ: begin
        if (imem_ready_i) begin
          if (redirect_now) begin
            pc_d = redirect_target;
          end else if (pend_valid_q) begin
            pc_d = pend_target_q;
          end else begin
            pc_d = pc_plus4_o;
          end
          pend_valid_d = 1'b0;
          pend_exc_d   = 1'b0;
          squash_d     = 1'b0;
          state_d      = stall_i ? HOLD : REQ;
        end else if (redirect_now) begin
          // Address must stay put until the memory answers, so only remember
          // where to go; a pending exception is never displaced by jump/branch.
          squash_d = 1'b1;
          if (exception_i || !(pend_valid_q && pend_exc_q)) begin
            pend_target_d = redirect_target;
            pend_valid_d  = 1'b1;
            pend_exc_d    = exception_i;
          end
        end
      end
      BOOT, HOLD: begin
        if (redirect_now) begin
          pc_d = redirect_target;
        end
        state_d = stall_i ? HOLD : REQ;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      epc_q         <= 32'h0;
      pend_target_q <= 32'h0;
      pend_valid_q  <= 1'b0;
      pend_exc_q    <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      pend_target_q <= pend_target_d;
      pend_valid_q  <= pend_valid_d;
      pend_exc_q    <= pend_exc_d;
      squash_q      <= squash_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed fetch scenarios followed by a
// randomized run, both judged against a cycle-level behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RV_A = 32'h0000_0000;
  localparam logic [31:0] RV_B = 32'hFFFF_FFFC;
  localparam logic [31:0] EXC_V = 32'h0000_0080;
  localparam int M_BOOT = 0;
  localparam int M_FETCH = 1;
  localparam int M_IDLE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jumpTarget = 32'h0;
  logic        exception = 1'b0;
  logic [31:0] excPc = 32'h0;
  logic        imemReady = 1'b1;

  logic        imemReqA, fetchValidA, imemReqB, fetchValidB;
  logic [31:0] imemAddrA, pcA, pcPlus4A, epcA;
  logic [31:0] imemAddrB, pcB, pcPlus4B, epcB;

  int checks = 0;
  int errors = 0;

  // Behavioural model: one abstract fetch mode plus a remembered redirect.
  int          mMode;
  logic [31:0] mPcA, mPcB, mEpc, mPendTarget;
  bit          mHavePend, mPendIsExc, mSquash;

  // Values sampled mid-cycle for the directed checks.
  logic        sReq, sValid;
  logic [31:0] sAddr, sEpc;

  pc_sequencer #(.RESET_VECTOR(RV_A), .EXC_VECTOR(EXC_V)) dutA (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .branch_taken_i(branchTaken), .branch_target_i(branchTarget),
    .jump_i(jump), .jump_target_i(jumpTarget),
    .exception_i(exception), .exc_pc_i(excPc),
    .imem_req_o(imemReqA), .imem_addr_o(imemAddrA), .imem_ready_i(imemReady),
    .pc_o(pcA), .pc_plus4_o(pcPlus4A), .fetch_valid_o(fetchValidA), .epc_o(epcA)
  );

  pc_sequencer #(.RESET_VECTOR(RV_B), .EXC_VECTOR(EXC_V)) dutB (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .branch_taken_i(branchTaken), .branch_target_i(branchTarget),
    .jump_i(jump), .jump_target_i(jumpTarget),
    .exception_i(exception), .exc_pc_i(excPc),
    .imem_req_o(imemReqB), .imem_addr_o(imemAddrB), .imem_ready_i(imemReady),
    .pc_o(pcB), .pc_plus4_o(pcPlus4B), .fetch_valid_o(fetchValidB), .epc_o(epcB)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    logic        anyRedirect;
    logic        expReq;
    logic        expValid;
    anyRedirect = exception | jump | branchTaken;
    expReq      = (mMode == M_FETCH);
    expValid    = expReq & imemReady & ~mSquash & ~mHavePend & ~anyRedirect;
    sReq   = imemReqA;
    sValid = fetchValidA;
    sAddr  = imemAddrA;
    sEpc   = epcA;
    cmp("reqA", imemReqA, expReq);
    cmp("addrA", imemAddrA, mPcA);
    cmp("pcA", pcA, mPcA);
    cmp("plus4A", pcPlus4A, mPcA + 32'd4);
    cmp("validA", fetchValidA, expValid);
    cmp("epcA", epcA, mEpc);
    cmp("reqB", imemReqB, expReq);
    cmp("addrB", imemAddrB, mPcB);
    cmp("plus4B", pcPlus4B, mPcB + 32'd4);
    cmp("validB", fetchValidB, expValid);
    cmp("epcB", epcB, mEpc);
  endtask

  task automatic modelStep();
    logic        anyRedirect;
    logic [31:0] tgt;
    if (rst) begin
      mMode = M_BOOT; mPcA = RV_A; mPcB = RV_B; mEpc = 32'h0;
      mHavePend = 0; mPendIsExc = 0; mSquash = 0; mPendTarget = 32'h0;
      return;
    end
    anyRedirect = exception | jump | branchTaken;
    tgt = exception ? EXC_V : (jump ? jumpTarget : branchTarget);
    tgt = tgt & 32'hFFFF_FFFC;
    if (exception) mEpc = excPc;
    if (mMode == M_FETCH && imemReady) begin
      if (anyRedirect) begin
        mPcA = tgt; mPcB = tgt;
      end else if (mHavePend) begin
        mPcA = mPendTarget; mPcB = mPendTarget;
      end else begin
        mPcA = mPcA + 32'd4; mPcB = mPcB + 32'd4;
      end
      mHavePend = 0; mPendIsExc = 0; mSquash = 0;
      mMode = stall ? M_IDLE : M_FETCH;
    end else if (mMode == M_FETCH) begin
      if (anyRedirect) begin
        mSquash = 1;
        if (exception || !mPendIsExc) begin
          mPendTarget = tgt; mHavePend = 1; mPendIsExc = exception;
        end
      end
    end else begin
      if (anyRedirect) begin
        mPcA = tgt; mPcB = tgt;
      end
      mMode = stall ? M_IDLE : M_FETCH;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic rdy,
                               input logic ex, input logic [31:0] ep,
                               input logic j, input logic [31:0] jt,
                               input logic b, input logic [31:0] bt);
    rst = r; stall = s; imemReady = rdy;
    exception = ex; excPc = ep;
    jump = j; jumpTarget = jt;
    branchTaken = b; branchTarget = bt;
  endtask

  initial begin
    mMode = M_BOOT; mPcA = RV_A; mPcB = RV_B; mEpc = 32'h0;
    mHavePend = 0; mPendIsExc = 0; mSquash = 0; mPendTarget = 32'h0;

    // Reset, then free-run with zero-wait memory.
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    modelStep();
    tick();
    cmp("rstPcA", pcA, 32'h0);
    cmp("rstPcB", pcB, 32'hFFFF_FFFC);
    cmp("rstWrapB", pcPlus4B, 32'h0);
    rst = 0;
    tick();
    cmp("bootNoReq", sReq, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp("seqReq", sReq, 1'b1);
      cmp("seqAddr", sAddr, 32'(i * 4));
      cmp("seqValid", sValid, 1'b1);
      if (i == 0) cmp("wrapPcB", pcB, 32'h0);
    end

    // Three wait states at 0x10.
    imemReady = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("waitAddr", sAddr, 32'h10);
      cmp("waitValid", sValid, 1'b0);
    end
    imemReady = 1;
    tick();
    cmp("waitDoneAddr", sAddr, 32'h10);
    cmp("waitDoneValid", sValid, 1'b1);
    cmp("afterWaitPc", pcA, 32'h14);
    tick(); tick(); tick();

    // Branch during a wait at 0x20 squashes that fetch.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h203);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    imemReady = 1;
    tick();
    cmp("brSquashAddr", sAddr, 32'h20);
    cmp("brSquashValid", sValid, 1'b0);
    tick();
    cmp("brTargetAddr", sAddr, 32'h200);
    cmp("brTargetValid", sValid, 1'b1);

    // Exception and jump together, then a later jump that must not win.
    applyStimulus(0, 0, 0, 1, 32'h30, 1, 32'h400, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h500, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    cmp("excSquashValid", sValid, 1'b0);
    tick();
    cmp("excAddr", sAddr, 32'h80);
    cmp("excEpc", sEpc, 32'h30);

    // Stall for five cycles with a jump arriving mid-stall.
    stall = 1;
    tick();
    cmp("stallHsValid", sValid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      jump = (i == 2); jumpTarget = 32'h100;
      tick();
      cmp("stallNoReq", sReq, 1'b0);
      cmp("stallAddr", sAddr, (i <= 2) ? 32'h88 : 32'h100);
    end
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    cmp("relAddr", sAddr, 32'h100);
    cmp("relValid", sValid, 1'b1);

    // Reset while a request is waiting.
    imemReady = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    tick();
    cmp("rstMidReq", sReq, 1'b0);
    cmp("rstMidAddr", sAddr, RV_A);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic quiet;
      quiet = (mMode == M_BOOT);
      applyStimulus($urandom_range(99) < 2,
                    $urandom_range(99) < 25,
                    $urandom_range(99) < 60,
                    !quiet && ($urandom_range(99) < 5), $urandom,
                    !quiet && ($urandom_range(99) < 8), $urandom,
                    !quiet && ($urandom_range(99) < 10), $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the program counter of the MIPS core and sequences instruction-memory requests. Each cycle it picks the next PC from sequential (PC+4), branch, jump and exception-vector sources. It holds the address stable across a multi-cycle instruction-memory handshake and squashes wrong-path fetches after a redirect. It sits between the hazard/branch/exception logic and the instruction memory, feeding PC and a valid strobe to the IF/ID register.

## Interface

- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: do not start a new fetch
- branch_taken  in  1  branch resolved taken this cycle
- branch_target  in  32  branch target address
- jump  in  1  jump resolved this cycle
- jump_target  in  32  jump target address
- exception  in  1  exception raised this cycle
- exc_pc  in  32  PC of faulting instruction
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (equals pc)
- imem_ready  in  1  memory accepts/completes request this cycle
- pc  out  32  current fetch PC (registered)
- pc_plus4  out  32  pc + 4, combinational
- fetch_valid  out  1  delivered instruction is on the correct path
- epc  out  32  saved exception PC

## Operation

- Reset (rst=1 at edge): pc=RESET_VECTOR, state=BOOT, epc=0, pending redirect cleared, squash flag cleared. rst dominates all other inputs.
- States:
  - BOOT: imem_req=0. Lasts one cycle, then HOLD if stall, else REQ.
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0, pc frozen except on redirect.
- Redirect priority in one cycle: exception > jump > branch_taken. Target = EXC_VECTOR, jump_target, or branch_target. Low 2 bits of every target are forced to 00.
- Exception: epc <= exc_pc on the same edge the exception is seen, in any state except reset.
- REQ handshake (imem_ready=1):
  - fetch_valid = 1 only if there is no pending redirect, the squash flag is clear, and no redirect is present this cycle.
  - Next pc: redirect this cycle, else pending target, else pc+4. Pending and squash are cleared.
  - Next state: HOLD if stall, else REQ.
- REQ without imem_ready:
  - imem_addr and imem_req must stay unchanged. stall is ignored.
  - A redirect sets squash=1 and records the pending target.
  - An exception always overwrites the pending target. Jump or branch overwrites it only if the pending target is not an exception.
- HOLD: a redirect loads pc <= target directly, with no squash. Next state is REQ once stall=0.
- Arithmetic: pc_plus4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing

- fetch_valid = imem_req & imem_ready & ~squash & ~pending & ~redirect_now. It is combinational, in the handshake cycle only.
- pc updates one edge after a handshake or HOLD redirect. Zero-wait memory gives one fetch per cycle.
- Redirect-to-new-request latency:
  - 1 cycle in HOLD, or in REQ with imem_ready the same cycle.
  - Otherwise 1 cycle after the pending handshake completes.
- First imem_req after rst falls: 2 cycles (BOOT, then REQ).
- Reset mid-transaction: imem_req drops on the next cycle. The memory must tolerate an abandoned request.
- stall rising during REQ takes effect only after the outstanding handshake completes.

## Test plan

- Reset then free-run, imem_ready=1, stall=0:
  - imem_req rises 2 cycles after rst falls.
  - pc steps 0x0, 0x4, 0x8, 0xC with fetch_valid=1 each cycle.
- Wait states, imem_ready low 3 cycles at pc=0x10:
  - imem_addr holds 0x10 for all 4 cycles.
  - A single fetch_valid pulse, then pc=0x14.
- branch_taken=1 with branch_target=0x203 during a wait at pc=0x20:
  - The 0x20 fetch completes with fetch_valid=0.
  - Next imem_addr=0x200.
- Same-cycle exception and jump (jump_target=0x400, exc_pc=0x30):
  - pc goes to 0x80 and epc=0x30.
  - A later jump pending behind an exception does not override it.
- Stall for 5 cycles after a handshake:
  - imem_req=0 and pc is frozen.
  - A jump to 0x100 during the stall loads pc=0x100 with no squash.
  - On release, the 0x100 fetch returns fetch_valid=1.
- Wrap and reset:
  - RESET_VECTOR=32'hFFFF_FFFC gives a next pc of 0x0.
  - rst asserted while imem_ready=0 gives imem_req=0 next cycle and pc=RESET_VECTOR.
